// File: rtl/dlsc_pcie_s6_outbound_read_alloc_pkg.sv
// Shared definitions for the outbound read allocation stage.
//   - FSM state encoding (INIT, IDLE, ALLOC, TLP)
//   - INIT_CYCLES: how long the read buffer is held idle after reset
//   - tlp_req_t: captured memory-read request (dword address, dword count, tag)
//   - dword_count(): converts a "dwords minus one" length into a dword count
package dlsc_pcie_s6_outbound_pkg;

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_ALLOC = 2'd2;
  localparam logic [1:0] ST_TLP   = 2'd3;

  localparam int INIT_CYCLES = 2;

  // Fields are sized for the widest supported configuration (ADDR < 64,
  // TAG < 8); users slice down to their own widths.
  typedef struct packed {
    logic [61:0] addr;
    logic [9:0]  len;
    logic [7:0]  tag;
  } tlp_req_t;

  function automatic logic [9:0] dword_count(input logic [9:0] len_m1);
    return len_m1 + 10'd1;
  endfunction

endpackage

// File: rtl/dlsc_pcie_s6_outbound_read_alloc_if.sv
// Bundle of the command, TLP request and read-buffer alloc/dealloc signals
// around the outbound read allocation stage.
//   master : the allocation stage (accepts commands, drives TLP and alloc)
//   slave  : its environment (command source, TLP generator, read buffer)
interface dlsc_pcie_s6_outbound_read_alloc_if #(
  parameter int ADDR = 32,
  parameter int LEN  = 4,
  parameter int TAG  = 5,
  parameter int BUFA = 9
);

  logic              cmd_ready;
  logic              cmd_valid;
  logic [ADDR-3:0]   cmd_addr;
  logic [LEN-1:0]    cmd_len;

  logic              tlp_ready;
  logic              tlp_valid;
  logic [ADDR-3:0]   tlp_addr;
  logic [9:0]        tlp_len;
  logic [TAG-1:0]    tlp_tag;

  logic              alloc_init;
  logic              alloc_valid;
  logic [TAG:0]      alloc_tag;
  logic [BUFA-1:0]   alloc_bufa;

  logic              dealloc_tag;
  logic              dealloc_data;

  modport master (
    output cmd_ready,
    input  cmd_valid, cmd_addr, cmd_len,
    input  tlp_ready,
    output tlp_valid, tlp_addr, tlp_len, tlp_tag,
    output alloc_init, alloc_valid, alloc_tag, alloc_bufa,
    input  dealloc_tag, dealloc_data
  );

  modport slave (
    input  cmd_ready,
    output cmd_valid, cmd_addr, cmd_len,
    output tlp_ready,
    input  tlp_valid, tlp_addr, tlp_len, tlp_tag,
    input  alloc_init, alloc_valid, alloc_tag, alloc_bufa,
    output dealloc_tag, dealloc_data
  );

endinterface

// File: rtl/dlsc_pcie_s6_outbound_credit_cnt.sv
// Free-credit counter: single-unit return (inc), multi-unit consume (dec_amt).
// Resets to MAX (everything free). Both ends saturate; returning a credit
// while already full is a protocol error flagged by a simulation assertion.
//   clk, rst_n : clock, async active-low reset
//   inc        : one credit returned this cycle
//   dec_amt    : credits consumed this cycle (0 when idle)
//   count      : credits currently free
module dlsc_pcie_s6_outbound_credit_cnt #(
  parameter int          W   = 6,
  parameter int unsigned MAX = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic [W-1:0] dec_amt,
  output logic [W-1:0] count
);

  logic         inc_ok;
  logic [W:0]   sum;
  logic [W-1:0] count_nxt;

  always_comb begin
    inc_ok    = inc && (count != W'(MAX));
    sum       = {1'b0, count} + (W+1)'(inc_ok);
    count_nxt = '0;
    if (sum >= {1'b0, dec_amt}) begin
      count_nxt = W'(sum - {1'b0, dec_amt});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= W'(MAX);
    end else begin
      count <= count_nxt;
    end
  end

  overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(inc && (count == W'(MAX))));

  underflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    ({1'b0, count} + (W+1)'(inc)) >= {1'b0, dec_amt});

endmodule

// File: rtl/dlsc_pcie_s6_outbound_read_alloc.sv
// Outbound read allocation stage. Reserves a completion tag and a contiguous
// span of read-buffer dwords for each pre-split read command, publishes the
// allocation to the read buffer, then hands the memory-read request to the
// TLP generator.
//   clk, rst_n          : clock, async active-low reset
//   bus.cmd_*           : incoming read commands (dword addr, len = dwords-1)
//   bus.tlp_*           : memory-read request towards the TLP generator
//   bus.alloc_*         : allocation write port of the read buffer
//   bus.dealloc_*       : per-tag / per-dword release pulses from the buffer
//
// state | meaning
// ------+------------------------------------------------------------
// INIT  | read buffer held idle (alloc_init) for INIT_CYCLES
// IDLE  | waiting for a command that fits in free tags and dwords
// ALLOC | one-cycle alloc_valid strobe, TLP request first presented
// TLP   | request held until the TLP generator accepts it
module dlsc_pcie_s6_outbound_read_alloc
  import dlsc_pcie_s6_outbound_pkg::*;
#(
  parameter int ADDR = 32,
  parameter int LEN  = 4,
  parameter int TAG  = 5,
  parameter int BUFA = 9
) (
  input  logic clk,
  input  logic rst_n,
  dlsc_pcie_s6_outbound_read_alloc_if.master bus
);

  localparam int DW_W  = BUFA + 1;
  localparam int TAG_W = TAG + 1;

  logic [1:0]       state;
  logic [1:0]       init_cnt;
  tlp_req_t         req;
  logic [TAG:0]     alloc_tag;
  logic [BUFA-1:0]  alloc_bufa;

  logic [TAG:0]     tags_free;
  logic [TAG:0]     tags_used;
  logic [BUFA:0]    dw_free;
  logic [BUFA:0]    cmd_need;
  logic [BUFA:0]    dw_dec;
  logic             alloc;
  logic             accept;
  logic             req_unused;

  assign alloc     = (state == ST_ALLOC);
  assign tags_used = TAG_W'(2**TAG) - tags_free;
  assign cmd_need  = DW_W'(dword_count(10'(bus.cmd_len)));
  assign dw_dec    = alloc ? DW_W'(req.len) : '0;

  // Only registered counters feed the fit check; cmd_len is the request itself.
  assign bus.cmd_ready = (state == ST_IDLE) &&
                         (tags_used < TAG_W'(2**TAG)) &&
                         (dw_free >= cmd_need);
  assign accept = bus.cmd_valid && bus.cmd_ready;

  assign bus.alloc_init  = (state == ST_INIT);
  assign bus.alloc_valid = alloc;
  assign bus.alloc_tag   = alloc_tag;
  assign bus.alloc_bufa  = alloc_bufa;

  // alloc_valid and the first tlp_valid cycle coincide, so the buffer's tag
  // table is written before any completion for this tag can come back.
  assign bus.tlp_valid = alloc || (state == ST_TLP);
  assign bus.tlp_addr  = req.addr[ADDR-3:0];
  assign bus.tlp_len   = req.len;
  assign bus.tlp_tag   = req.tag[TAG-1:0];

  assign req_unused = ^{req.addr[61:ADDR-2], req.tag[7:TAG]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_INIT;
      init_cnt   <= 2'(INIT_CYCLES - 1);
      req        <= '0;
      alloc_tag  <= '0;
      alloc_bufa <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          if (init_cnt == 2'd0) begin
            state <= ST_IDLE;
          end else begin
            init_cnt <= init_cnt - 2'd1;
          end
        end
        ST_IDLE: begin
          if (accept) begin
            // alloc_tag cannot move before ALLOC ends, so it is safe to
            // latch the request tag here.
            req.addr <= 62'(bus.cmd_addr);
            req.len  <= dword_count(10'(bus.cmd_len));
            req.tag  <= 8'(alloc_tag[TAG-1:0]);
            state    <= ST_ALLOC;
          end
        end
        ST_ALLOC: begin
          alloc_tag  <= alloc_tag + TAG_W'(1);
          alloc_bufa <= alloc_bufa + BUFA'(req.len);
          state      <= bus.tlp_ready ? ST_IDLE : ST_TLP;
        end
        ST_TLP: begin
          if (bus.tlp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  dlsc_pcie_s6_outbound_credit_cnt #(
    .W   (TAG_W),
    .MAX (2**TAG)
  ) u_tag_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (bus.dealloc_tag),
    .dec_amt (TAG_W'(alloc)),
    .count   (tags_free)
  );

  dlsc_pcie_s6_outbound_credit_cnt #(
    .W   (DW_W),
    .MAX (2**BUFA)
  ) u_dw_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (bus.dealloc_data),
    .dec_amt (dw_dec),
    .count   (dw_free)
  );

endmodule

// File: tb/tb_dlsc_pcie_s6_outbound_read_alloc.sv
module tb_dlsc_pcie_s6_outbound_read_alloc;

  logic clk = 1'b0;
  logic rst_n;
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  dlsc_pcie_s6_outbound_read_alloc_if #(.ADDR(32), .LEN(4), .TAG(5), .BUFA(9)) bus ();

  dlsc_pcie_s6_outbound_read_alloc #(.ADDR(32), .LEN(4), .TAG(5), .BUFA(9)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();
  endtask

  // Presents a command, waits (bounded) for acceptance; returns in ALLOC.
  task automatic send_cmd(input logic [29:0] a, input logic [3:0] l);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    while (!bus.cmd_ready && n < 50) begin
      step();
      n++;
    end
    chk("cmd_accept_wait", 32'(bus.cmd_ready), 32'd1);
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic issue(input logic [29:0] a, input logic [3:0] l);
    send_cmd(a, l);
    step();
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.cmd_valid    = 1'b0;
    bus.cmd_addr     = '0;
    bus.cmd_len      = '0;
    bus.tlp_ready    = 1'b1;
    bus.dealloc_tag  = 1'b0;
    bus.dealloc_data = 1'b0;

    // Reset values
    step();
    chk("rst_alloc_init",  32'(bus.alloc_init), 32'd1);
    chk("rst_alloc_valid", 32'(bus.alloc_valid), 32'd0);
    chk("rst_tlp_valid",   32'(bus.tlp_valid), 32'd0);
    chk("rst_cmd_ready",   32'(bus.cmd_ready), 32'd0);
    chk("rst_alloc_tag",   32'(bus.alloc_tag), 32'd0);
    chk("rst_alloc_bufa",  32'(bus.alloc_bufa), 32'd0);
    chk("rst_tags_used",   32'(dut.tags_used), 32'd0);
    chk("rst_dw_free",     32'(dut.dw_free), 32'd512);

    // INIT lasts two cycles after release
    rst_n = 1'b1;
    step();
    chk("init_cycle1", 32'(bus.alloc_init), 32'd1);
    step();
    chk("init_done", 32'(bus.alloc_init), 32'd0);

    // First command: byte 0x1000 -> dword 0x400, len 3
    send_cmd(30'h400, 4'd3);
    chk("c1_alloc_valid", 32'(bus.alloc_valid), 32'd1);
    chk("c1_alloc_tag",   32'(bus.alloc_tag), 32'd0);
    chk("c1_alloc_bufa",  32'(bus.alloc_bufa), 32'd0);
    chk("c1_tlp_valid",   32'(bus.tlp_valid), 32'd1);
    chk("c1_tlp_addr",    32'(bus.tlp_addr), 32'h400);
    chk("c1_tlp_len",     32'(bus.tlp_len), 32'd4);
    chk("c1_tlp_tag",     32'(bus.tlp_tag), 32'd0);
    step();
    chk("c1_post_valid", 32'(bus.alloc_valid), 32'd0);
    chk("c1_next_tag",   32'(bus.alloc_tag), 32'd1);
    chk("c1_next_bufa",  32'(bus.alloc_bufa), 32'd4);
    chk("c1_tags_used",  32'(dut.tags_used), 32'd1);
    chk("c1_dw_free",    32'(dut.dw_free), 32'd508);

    // Tag exhaustion
    do_reset();
    for (int i = 0; i < 32; i++) issue(30'(i), 4'd0);
    chk("tx_tags_used", 32'(dut.tags_used), 32'd32);
    chk("tx_alloc_tag", 32'(bus.alloc_tag), 32'd32);
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = 4'd0;
    step(); step(); step();
    chk("tx_held_ready", 32'(bus.cmd_ready), 32'd0);
    chk("tx_held_alloc", 32'(bus.alloc_valid), 32'd0);
    bus.dealloc_tag = 1'b1;
    step();
    bus.dealloc_tag = 1'b0;
    chk("tx_after_dealloc_used", 32'(dut.tags_used), 32'd31);
    chk("tx_after_dealloc_ready", 32'(bus.cmd_ready), 32'd1);
    step();
    bus.cmd_valid = 1'b0;
    chk("tx33_alloc_valid", 32'(bus.alloc_valid), 32'd1);
    chk("tx33_alloc_tag",   32'(bus.alloc_tag), 32'h20);
    chk("tx33_tlp_tag",     32'(bus.tlp_tag), 32'd0);
    chk("tx33_alloc_bufa",  32'(bus.alloc_bufa), 32'd32);
    step();

    // Buffer exhaustion (also exercises exact-fit acceptance)
    do_reset();
    for (int i = 0; i < 32; i++) issue(30'(i * 16), 4'd15);
    chk("bx_dw_free",    32'(dut.dw_free), 32'd0);
    chk("bx_alloc_bufa", 32'(bus.alloc_bufa), 32'd0);
    chk("bx_tags_used",  32'(dut.tags_used), 32'd32);
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = 4'd0;
    step();
    chk("bx_held_ready", 32'(bus.cmd_ready), 32'd0);
    bus.dealloc_tag = 1'b1;
    step();
    bus.dealloc_tag = 1'b0;
    chk("bx_tag_only_ready", 32'(bus.cmd_ready), 32'd0);
    bus.dealloc_data = 1'b1;
    step();
    bus.dealloc_data = 1'b0;
    chk("bx_dw_free_one", 32'(dut.dw_free), 32'd1);
    chk("bx_ready", 32'(bus.cmd_ready), 32'd1);
    step();
    bus.cmd_valid = 1'b0;
    chk("bx_alloc_valid", 32'(bus.alloc_valid), 32'd1);
    chk("bx_alloc_bufa_wrap", 32'(bus.alloc_bufa), 32'd0);
    chk("bx_alloc_tag", 32'(bus.alloc_tag), 32'h20);
    step();
    chk("bx_dw_free_zero", 32'(dut.dw_free), 32'd0);

    // TLP back-pressure
    do_reset();
    bus.tlp_ready = 1'b0;
    send_cmd(30'h2345, 4'd5);
    chk("st_alloc_valid", 32'(bus.alloc_valid), 32'd1);
    chk("st_tlp_valid0",  32'(bus.tlp_valid), 32'd1);
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("st_tlp_valid", 32'(bus.tlp_valid), 32'd1);
      chk("st_tlp_addr",  32'(bus.tlp_addr), 32'h2345);
      chk("st_tlp_len",   32'(bus.tlp_len), 32'd6);
      chk("st_tlp_tag",   32'(bus.tlp_tag), 32'd0);
      chk("st_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      chk("st_no_alloc",  32'(bus.alloc_valid), 32'd0);
    end
    bus.cmd_valid = 1'b0;
    bus.tlp_ready = 1'b1;
    step();
    chk("st_released", 32'(bus.tlp_valid), 32'd0);
    chk("st_next_tag",  32'(bus.alloc_tag), 32'd1);
    chk("st_next_bufa", 32'(bus.alloc_bufa), 32'd6);

    // Simultaneous alloc and dealloc: tags 1, dwords 506 before
    send_cmd(30'h100, 4'd7);
    bus.dealloc_data = 1'b1;
    bus.dealloc_tag  = 1'b1;
    step();
    bus.dealloc_data = 1'b0;
    bus.dealloc_tag  = 1'b0;
    chk("sim_tags_used", 32'(dut.tags_used), 32'd1);
    chk("sim_dw_free",   32'(dut.dw_free), 32'd499);

    // Asynchronous reset while holding a TLP request
    bus.tlp_ready = 1'b0;
    send_cmd(30'h3000, 4'd2);
    step();
    chk("ar_tlp_pending", 32'(bus.tlp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_tlp_valid",   32'(bus.tlp_valid), 32'd0);
    chk("ar_alloc_init",  32'(bus.alloc_init), 32'd1);
    chk("ar_cmd_ready",   32'(bus.cmd_ready), 32'd0);
    chk("ar_tags_used",   32'(dut.tags_used), 32'd0);
    chk("ar_dw_free",     32'(dut.dw_free), 32'd512);
    chk("ar_alloc_tag",   32'(bus.alloc_tag), 32'd0);
    chk("ar_alloc_bufa",  32'(bus.alloc_bufa), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("ar_init_done", 32'(bus.alloc_init), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dlsc_pcie_s6_outbound_read_alloc.md
Name: dlsc_pcie_s6_outbound_read_alloc

Overview:
Allocation stage directly upstream of the outbound read buffer. It accepts pre-split outbound read commands (no 4 KB crossing, ≤ 2^LEN dwords). For each command it reserves a completion tag and a contiguous span of read-buffer dwords, then publishes the allocation to the read buffer's alloc port. It then issues the memory-read TLP request downstream. Buffer dwords and tags return via the read buffer's dealloc_data / dealloc_tag pulses.

Parameters:
- ADDR, 32: byte address width; commands carry dword address bits [ADDR-1:2].
- LEN, 4: command length width; a command covers len+1 dwords. Constraint: LEN ≤ 9.
- TAG, 5: tag width; 2^TAG tags. alloc_tag carries one extra wrap bit.
- BUFA, 9: read-buffer address width; 2^BUFA dwords.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_ready  out  1  command accept
- cmd_valid  in  1  command present
- cmd_addr  in  ADDR-2  dword start address
- cmd_len  in  LEN  dwords minus one
- tlp_ready  in  1  TLP generator accepts request
- tlp_valid  out  1  request present
- tlp_addr  out  ADDR-2  dword address
- tlp_len  out  10  dword count (cmd_len+1)
- tlp_tag  out  TAG  PCIe tag
- alloc_init  out  1  read buffer held idle during initialisation
- alloc_valid  out  1  one-cycle allocation write strobe
- alloc_tag  out  TAG+1  next tag to allocate (with wrap bit)
- alloc_bufa  out  BUFA  buffer start address for alloc_tag
- dealloc_tag  in  1  one tag freed (pulse)
- dealloc_data  in  1  one buffer dword freed (pulse)

Behaviour:
- Reset (async assert, sync-released internally via registers only): state=INIT. Output values during reset:
  - alloc_init=1
  - alloc_valid=0, tlp_valid=0, cmd_ready=0
  - alloc_tag=0, alloc_bufa=0
  - tags_used=0, dw_free=2^BUFA (BUFA+1 bits)
  - Reset mid-operation discards any pending TLP. The read buffer is assumed reset together with this block.
- INIT: lasts 2 cycles after reset release (counter), with alloc_init=1, then → IDLE with alloc_init=0.
- IDLE: cmd_ready = (tags_used < 2^TAG) && (dw_free ≥ cmd_len+1). It is computed from registered counters only (combinational AND with cmd_valid allowed). On accept:
  - Capture addr/len.
  - → ALLOC.
- ALLOC (1 cycle):
  - alloc_valid=1 with the current alloc_tag/alloc_bufa.
  - tlp_valid=1, tlp_tag=alloc_tag[TAG-1:0].
  - Next cycle: alloc_tag+=1 (mod 2^(TAG+1)), alloc_bufa+=len+1 (mod 2^BUFA), tags_used+=1, dw_free-=len+1.
  - If tlp_ready → IDLE, else → TLP.
- TLP: tlp_valid held with stable fields until tlp_ready → IDLE. cmd_ready=0 outside IDLE. Throughput: one command per 2 cycles max.
- alloc_valid fires before or with tlp_valid's first cycle, so the tag table is written before any completion can return.
- Counter updates in the same cycle combine:
  - tags_used += alloc − dealloc_tag.
  - dw_free += dealloc_data − (alloc ? len+1 : 0).
- Overflow guard: dealloc_tag while tags_used==0, or dealloc_data while dw_free==2^BUFA, is a protocol error. Counters saturate, and a sim-only assertion fires.
- Boundary: a command needing exactly dw_free dwords is accepted, leaving dw_free=0. alloc_bufa wraps across 2^BUFA, and the read buffer addresses modulo.

Decomposition:
- Package dlsc_pcie_s6_outbound_pkg: FSM state encoding (INIT, IDLE, ALLOC, TLP), INIT_CYCLES=2, and a TLP request struct (addr, len, tag).
- One natural sub-module: dlsc_pcie_s6_outbound_credit_cnt. It is a generic up/down counter with multi-unit decrement, single-unit increment and saturation, instanced twice (tags, dwords).

Test Plan:
- Reset release: alloc_init=1 for 2 cycles then 0; first command addr=0x1000, len=3 → alloc_valid with alloc_tag=0, alloc_bufa=0; tlp_len=4, tlp_tag=0. Next alloc_bufa=4, alloc_tag=1.
- Tag exhaustion (TAG=5): 32 back-to-back len=0 commands, no dealloc → 33rd held (cmd_ready=0). One dealloc_tag pulse → accepted with alloc_tag=32 (wrap bit set), tlp_tag=0.
- Buffer exhaustion (BUFA=9): 32 commands of len=15 → dw_free=0. A len=0 command blocks until one dealloc_data, then alloc_bufa=0 (wrap).
- tlp_ready low for 5 cycles → tlp_valid and fields stable, cmd_ready=0 throughout, no second alloc_valid.
- Simultaneous alloc (len=7) and dealloc_data/dealloc_tag in same cycle → dw_free net −7, tags_used net 0.
- Async rst_n assert while in TLP state → tlp_valid=0 immediately, counters restored, alloc_init=1.
